// File: rtl/counter_ctrl.sv
// counter_ctrl: sequences an external counter through clear, run and
// completion. It counts terminal-count pulses against a latched run target
// and supports a stop-abort that captures the live count value.
module counter_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [RUN_W-1:0] runs_req,
  input  logic [CNT_W-1:0] count_in,
  input  logic             tc_in,
  output logic             cnt_ena,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [RUN_W-1:0] runs_done,
  output logic [CNT_W-1:0] last_count
);

  localparam int unsigned RUN_XW = RUN_W + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [RUN_W-1:0]  target;
  logic              accept;
  logic              abort;
  logic              tc_count;
  logic              finish;
  logic [RUN_W-1:0]  runs_inc;
  logic [RUN_XW-1:0] runs_plus;

  // Event decodes shared by the state machine and the datapath registers.
  always_comb begin
    accept    = 1'b0;
    abort     = 1'b0;
    tc_count  = 1'b0;
    finish    = 1'b0;
    runs_plus = RUN_XW'(runs_done) + RUN_XW'(1);
    runs_inc  = (runs_done == RUN_MAX) ? runs_done : RUN_W'(runs_plus);
    case (state)
      IDLE:  accept = start && !stop;
      CLEAR: abort  = stop;
      RUN: begin
        abort    = stop;
        tc_count = tc_in && !stop;
        finish   = tc_count && (target != '0)
                   && (runs_plus == RUN_XW'(target));
      end
      default: ;
    endcase
  end

  // Next-state logic; stop outranks a same-cycle terminal count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = CLEAR;
      end
      CLEAR: begin
        if (abort) state_next = IDLE;
        else       state_next = RUN;
      end
      RUN: begin
        if (abort)       state_next = IDLE;
        else if (finish) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Counter controls and busy registered from the next state, so they track
  // the state register exactly as Moore decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_ena <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      cnt_ena <= (state_next == RUN);
      cnt_clr <= (state_next == CLEAR);
      busy    <= (state_next == CLEAR) || (state_next == RUN);
      done    <= (state_next == DONE);
      aborted <= abort;
    end
  end

  // Run target, latched only when a start is accepted.
  always_ff @(posedge clk) begin
    if (reset)       target <= '0;
    else if (accept) target <= runs_req;
  end

  // Terminal-count tally: cleared while in CLEAR, saturating in RUN.
  always_ff @(posedge clk) begin
    if (reset)                runs_done <= '0;
    else if (state == CLEAR)  runs_done <= '0;
    else if (tc_count)        runs_done <= runs_inc;
  end

  // Live count snapshot taken on a stop-abort from RUN.
  always_ff @(posedge clk) begin
    if (reset)                         last_count <= '0;
    else if (abort && (state == RUN))  last_count <= count_in;
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: randomized sequences against a behavioural model; the
// expected completion/abort records go through a queue to a monitor.
module tb_counter_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned RUN_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic [RUN_W-1:0] runs_req;
  logic [CNT_W-1:0] count_in;
  logic             tc_in;
  logic             cnt_ena;
  logic             cnt_clr;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [RUN_W-1:0] runs_done;
  logic [CNT_W-1:0] last_count;

  typedef struct packed {
    logic             is_done;
    logic [RUN_W-1:0] runs;
    logic [CNT_W-1:0] last;
  } exp_t;

  exp_t             q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] last_exp;

  counter_ctrl #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .runs_req(runs_req), .count_in(count_in), .tc_in(tc_in),
    .cnt_ena(cnt_ena), .cnt_clr(cnt_clr), .busy(busy), .done(done),
    .aborted(aborted), .runs_done(runs_done), .last_count(last_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RUN_W-1:0] sat(input int n);
    int m;
    m = (n > 255) ? 255 : n;
    return m[RUN_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done/aborted pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset && (done || aborted)) begin
      exp_t e;
      check("done_xor_aborted", 32'(done && aborted), 32'd0);
      if (q.size() == 0) begin
        check("unexpected_event", 32'(done), 32'(aborted));
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b aborted=%0b with empty queue @%0t", done, aborted, $time);
      end else begin
        e = q.pop_front();
        check("event_kind_done", 32'(done), 32'(e.is_done));
        check("runs_done", 32'(runs_done), 32'(e.runs));
        check("last_count", 32'(last_count), 32'(e.last));
      end
    end
  end

  // One full sequence; abort_after = number of tc pulses before stop (-1 none).
  task automatic run_seq(input int req, input int abort_after, input bit collide,
                         input bit poke_start, input logic [CNT_W-1:0] abort_val);
    int k;
    int gap;
    k = 0;
    start = 1'b1;
    runs_req = RUN_W'(req);
    step();
    start = 1'b0;
    runs_req = RUN_W'($urandom);
    check("clr_pulse", 32'(cnt_clr), 32'd1);
    check("busy_in_clear", 32'(busy), 32'd1);
    check("ena_off_in_clear", 32'(cnt_ena), 32'd0);
    step();
    check("clr_one_cycle", 32'(cnt_clr), 32'd0);
    check("ena_in_run", 32'(cnt_ena), 32'd1);
    check("runs_cleared", 32'(runs_done), 32'd0);
    forever begin
      if (k == abort_after) begin
        count_in = abort_val;
        stop = 1'b1;
        tc_in = collide;
        q.push_back('{is_done: 1'b0, runs: sat(k), last: abort_val});
        last_exp = abort_val;
        step();
        stop = 1'b0;
        tc_in = 1'b0;
        check("ena_off_after_abort", 32'(cnt_ena), 32'd0);
        check("busy_off_after_abort", 32'(busy), 32'd0);
        break;
      end
      gap = poke_start ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        count_in = CNT_W'($urandom);
        if (poke_start) begin
          start = 1'b1;
          runs_req = RUN_W'(7);
        end
        step();
        start = 1'b0;
        check("ena_held_in_run", 32'(cnt_ena), 32'd1);
        check("no_clr_in_run", 32'(cnt_clr), 32'd0);
      end
      tc_in = 1'b1;
      count_in = CNT_W'($urandom);
      if (req != 0 && k + 1 == req)
        q.push_back('{is_done: 1'b1, runs: sat(k + 1), last: last_exp});
      step();
      tc_in = 1'b0;
      k++;
      if (req != 0 && k == req) begin
        check("ena_off_at_done", 32'(cnt_ena), 32'd0);
        check("busy_off_at_done", 32'(busy), 32'd0);
        step();
        check("idle_ena_off", 32'(cnt_ena), 32'd0);
        check("idle_clr_off", 32'(cnt_clr), 32'd0);
        check("runs_held_idle", 32'(runs_done), 32'(sat(k)));
        break;
      end
      check("runs_count", 32'(runs_done), 32'(sat(k)));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"}, 32'(cnt_ena), 32'd0);
    check({tag, "_clr"}, 32'(cnt_clr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_runs"}, 32'(runs_done), 32'd0);
    check({tag, "_last"}, 32'(last_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    runs_req = '0;
    count_in = '0;
    tc_in = 1'b0;
    last_exp = '0;
    step();
    step();
    check_all_zero("reset_state");
    reset = 1'b0;

    // Normal two-run sequence.
    run_seq(2, -1, 1'b0, 1'b0, '0);
    step();
    // Abort after one terminal count.
    run_seq(5, 1, 1'b0, 1'b0, 16'h1234);
    step();
    // Stop colliding with tc: that tc is not counted.
    run_seq(4, 2, 1'b1, 1'b0, CNT_W'($urandom));

    // start with stop in IDLE is refused.
    start = 1'b1;
    stop = 1'b1;
    runs_req = RUN_W'(3);
    step();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_no_clr", 32'(cnt_clr), 32'd0);
    check("startstop_idle", 32'(busy), 32'd0);
    check("startstop_runs_held", 32'(runs_done), 32'd2);
    step();
    check("startstop_still_idle", 32'(busy), 32'd0);

    // Abort while in CLEAR: tally already zeroed, snapshot unchanged.
    start = 1'b1;
    runs_req = RUN_W'(3);
    step();
    start = 1'b0;
    stop = 1'b1;
    q.push_back('{is_done: 1'b0, runs: '0, last: last_exp});
    step();
    stop = 1'b0;
    check("clear_abort_idle", 32'(busy), 32'd0);
    check("clear_abort_no_ena", 32'(cnt_ena), 32'd0);

    // Free run saturates and needs a stop.
    run_seq(0, 300, 1'b0, 1'b0, CNT_W'($urandom));
    step();
    // start pokes during RUN are ignored; original target of 3 stands.
    run_seq(3, -1, 1'b0, 1'b1, '0);

    // Reset in the middle of RUN.
    start = 1'b1;
    runs_req = RUN_W'(5);
    step();
    start = 1'b0;
    step();
    tc_in = 1'b1;
    step();
    tc_in = 1'b0;
    reset = 1'b1;
    step();
    step();
    check_all_zero("midrun_reset");
    last_exp = '0;
    reset = 1'b0;
    // Start accepted on the first cycle out of reset.
    run_seq(1, -1, 1'b0, 1'b0, '0);

    // Random sequences.
    for (int i = 0; i < 20; i++) begin
      int req;
      int ab;
      req = int'($urandom_range(0, 6));
      ab = ($urandom_range(0, 2) == 0 || req == 0) ? int'($urandom_range(0, 5)) : -1;
      if (req != 0 && ab >= req) ab = -1;
      run_seq(req, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CNT_W'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    step();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
